pipe_inv: RTL and testbench



---
 rtl/pipe_inv_if.sv | 49 ++++
 rtl/pipe_inv.sv | 160 ++++++++++++++++
 tb/tb_pipe_inv.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_inv_if.sv
// -----------------------------------------------------------------------------
// pipe_inv_if
//   Handshake/data bundle for the pipe_inv sequential divider.
//
//   Producer side (request):  in_valid, in_ready, F (dividend), D (divisor)
//   Consumer side (result):   out_valid, out_ready, Q (quotient),
//                             R (remainder), div_zero
//
//   Modports:
//     master - the environment driving requests and accepting results
//     slave  - the divider itself
// -----------------------------------------------------------------------------
interface pipe_inv_if #(
    parameter int N = 10
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] F;
    logic [N-1:0] D;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Q;
    logic [N-1:0] R;
    logic         div_zero;

    modport master (
        output in_valid,
        output F,
        output D,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Q,
        input  R,
        input  div_zero
    );

    modport slave (
        input  in_valid,
        input  F,
        input  D,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Q,
        output R,
        output div_zero
    );
endinterface

// File: rtl/pipe_inv.sv
// -----------------------------------------------------------------------------
// pipe_inv
//   Sequential unsigned radix-2 restoring divider that recovers x3 = F / D
//   (plus remainder) from the output of the pipe_ex datapath. One quotient
//   bit is produced per clock, so a non-zero divide takes N cycles after the
//   accept edge. A zero divisor short-circuits straight to a result of
//   Q = all ones, R = F, div_zero = 1.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset (clears control and data)
//     bus  - pipe_inv_if.slave:
//              in_valid/in_ready  request handshake (in_ready = idle)
//              F, D               dividend / divisor, unsigned N bits
//              out_valid/out_ready result handshake (out_valid = done)
//              Q, R, div_zero     quotient, remainder, zero-divisor flag
// -----------------------------------------------------------------------------
module pipe_inv #(
    parameter int N = 10
) (
    input logic       clk,
    input logic       rst,
    pipe_inv_if.slave bus
);

    localparam int CNT_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // The dividend register doubles as the quotient register: each DIV
    // cycle shifts one dividend bit out of the top and one quotient bit in
    // at the bottom, so after N iterations it holds the full quotient.
    logic [N-1:0]     dividend;
    logic [N-1:0]     divisor;
    logic [N-1:0]     prem;
    logic [CNT_W-1:0] cnt;

    logic [N-1:0]     q_r;
    logic [N-1:0]     r_r;
    logic             dz_r;

    logic [N:0]       p_shift;
    logic             ge;
    logic [N-1:0]     p_sub;
    logic [N-1:0]     rem_next;
    logic [N-1:0]     quo_next;
    logic             last_iter;

    // -------------------------------------------------------------------------
    // Restoring divide step
    // -------------------------------------------------------------------------
    // The shifted remainder can reach 2*divisor-1, which needs N+1 bits; the
    // compare is done at that full width. Once the subtraction is taken the
    // result is strictly below the divisor, so N bits hold it exactly and
    // the modulo-2^N subtraction below is exact.
    always_comb begin
        p_shift  = {prem, dividend[N-1]};
        ge       = (p_shift >= {1'b0, divisor});
        p_sub    = p_shift[N-1:0] - divisor;
        rem_next = ge ? p_sub : p_shift[N-1:0];
        quo_next = {dividend[N-2:0], ge};
    end

    assign last_iter = (state_q == DIV) && (cnt == '0);

    // -------------------------------------------------------------------------
    // Control: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Control: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = (bus.D == '0) ? DONE : DIV;
                end
            end
            DIV: begin
                if (cnt == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: operand capture, iteration, result load
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dividend <= '0;
            divisor  <= '0;
            prem     <= '0;
            cnt      <= '0;
            q_r      <= '0;
            r_r      <= '0;
            dz_r     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        dividend <= bus.F;
                        divisor  <= bus.D;
                        prem     <= '0;
                        if (bus.D == '0) begin
                            q_r  <= '1;
                            r_r  <= bus.F;
                            dz_r <= 1'b1;
                        end else begin
                            cnt <= CNT_W'(N - 1);
                        end
                    end
                end
                DIV: begin
                    dividend <= quo_next;
                    prem     <= rem_next;
                    if (last_iter) begin
                        q_r  <= quo_next;
                        r_r  <= rem_next;
                        dz_r <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags decode registered state only.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.Q         = q_r;
    assign bus.R         = r_r;
    assign bus.div_zero  = dz_r;

endmodule

// File: tb/tb_pipe_inv.sv
// -----------------------------------------------------------------------------
// tb_pipe_inv
//   Self-checking bench for pipe_inv: directed scenarios followed by random
//   divides, checked against a plain-arithmetic quotient/remainder model.
// -----------------------------------------------------------------------------
module tb_pipe_inv;

    localparam int N = 10;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_inv_if #(.N(N)) bus ();

    pipe_inv #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, with the zero-divisor convention.
    task automatic model(input logic [N-1:0] f, input logic [N-1:0] d,
                         output logic [N-1:0] q, output logic [N-1:0] r,
                         output logic dz);
        if (d == 0) begin
            q  = '1;
            r  = f;
            dz = 1'b1;
        end else begin
            q  = N'(int'(f) / int'(d));
            r  = N'(int'(f) % int'(d));
            dz = 1'b0;
        end
    endtask

    // One complete transaction: accept, wait for result, check latency and
    // values, optionally hold backpressure for bp cycles, then release.
    task automatic run_div(input string tag, input logic [N-1:0] f,
                           input logic [N-1:0] d, input int bp);
        logic [N-1:0] eq, er;
        logic         edz;
        int           w;
        int           lat;
        logic         busy_ready;
        model(f, d, eq, er, edz);

        w = 0;
        while (!bus.in_ready && w < 50) begin
            tick();
            w++;
        end
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);

        bus.in_valid = 1'b1;
        bus.F        = f;
        bus.D        = d;
        tick();
        bus.in_valid = 1'b0;
        bus.F        = N'($urandom);
        bus.D        = N'($urandom);

        lat        = 0;
        busy_ready = 1'b0;
        while (!bus.out_valid && lat < 3 * N) begin
            if (bus.in_ready) busy_ready = 1'b1;
            tick();
            lat++;
        end
        if (bus.in_ready) busy_ready = 1'b1;
        check({tag, "_lat"}, 32'(lat), (d == 0) ? 32'd0 : 32'(N));
        check({tag, "_busy_in_ready"}, 32'(busy_ready), 32'd0);
        check({tag, "_q"}, 32'(bus.Q), 32'(eq));
        check({tag, "_r"}, 32'(bus.R), 32'(er));
        check({tag, "_dz"}, 32'(bus.div_zero), 32'(edz));

        for (int i = 0; i < bp; i++) begin
            bus.in_valid = 1'($urandom);
            bus.F        = N'($urandom);
            bus.D        = N'($urandom);
            tick();
            check({tag, "_bp_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_bp_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, "_bp_q"}, 32'(bus.Q), 32'(eq));
            check({tag, "_bp_r"}, 32'(bus.R), 32'(er));
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_release_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] bf [3];
        logic [N-1:0] bd [3];
        logic [N-1:0] eq, er;
        logic         edz;
        int           prev_acc;
        int           acc;
        int           lat;
        logic         busy_ready;
        logic [N-1:0] rf, rd;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.F         = '0;
        bus.D         = '0;

        // Reset values
        rst = 1'b1;
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_q", 32'(bus.Q), 32'd0);
        check("rst_r", 32'(bus.R), 32'd0);
        check("rst_dz", 32'(bus.div_zero), 32'd0);
        rst = 1'b0;
        tick();

        // Basic divide, latency N
        run_div("basic", 10'd32, 10'd2, 0);

        // Back-to-back with out_ready high and in_valid held high
        bf[0] = 10'd66; bd[0] = 10'd3;
        bf[1] = 10'd44; bd[1] = 10'd4;
        bf[2] = 10'd5;  bd[2] = 10'd7;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        prev_acc      = 0;
        for (int i = 0; i < 3; i++) begin
            check("b2b_idle", 32'(bus.in_ready), 32'd1);
            bus.F = bf[i];
            bus.D = bd[i];
            acc   = cyc;
            if (i > 0) check("b2b_interval", 32'(acc - prev_acc), 32'(N + 2));
            prev_acc = acc;
            tick();
            bus.F = N'($urandom);
            bus.D = N'($urandom);
            lat        = 0;
            busy_ready = 1'b0;
            while (!bus.out_valid && lat < 3 * N) begin
                if (bus.in_ready) busy_ready = 1'b1;
                tick();
                lat++;
            end
            if (bus.in_ready) busy_ready = 1'b1;
            model(bf[i], bd[i], eq, er, edz);
            check("b2b_lat", 32'(lat), 32'(N));
            check("b2b_busy_in_ready", 32'(busy_ready), 32'd0);
            check("b2b_q", 32'(bus.Q), 32'(eq));
            check("b2b_r", 32'(bus.R), 32'(er));
            if (i == 2) bus.in_valid = 1'b0;
            tick();
        end
        bus.out_ready = 1'b0;
        check("b2b_end_idle", 32'(bus.in_ready), 32'd1);

        // Width extremes
        run_div("ext_max_1", 10'd1023, 10'd1, 0);
        run_div("ext_max_max", 10'd1023, 10'd1023, 0);
        run_div("ext_below", 10'd1022, 10'd1023, 0);
        run_div("ext_512", 10'd1023, 10'd512, 0);

        // Divide-by-zero, then a normal divide clears the flag
        run_div("dz", 10'd100, 10'd0, 0);
        run_div("after_dz", 10'd9, 10'd3, 0);

        // Backpressure in DONE for five cycles
        run_div("bp", 10'd200, 10'd9, 5);

        // Reset during the 4th DIV cycle
        bus.in_valid = 1'b1;
        bus.F        = 10'd500;
        bus.D        = 10'd7;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("mid_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_q", 32'(bus.Q), 32'd0);
        check("mid_rst_r", 32'(bus.R), 32'd0);
        check("mid_rst_dz", 32'(bus.div_zero), 32'd0);
        run_div("after_rst", 10'd500, 10'd7, 0);

        // Randomised divides
        for (int i = 0; i < 25; i++) begin
            rf = N'($urandom_range(0, 1023));
            rd = ($urandom_range(0, 7) == 0) ? 10'd0 : N'($urandom_range(1, 1023));
            run_div("rand", rf, rd, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
